// File: rtl/regfile_read_arbiter_if.sv
// Bundle of requester, register-file, commit and response signals for the
// register-file read arbiter. The arbiter uses the slave modport.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][4:0]       req_rs1;
  logic [NUM_REQ-1:0][4:0]       req_rs2;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;

  logic [4:0]                    rf_rs1;
  logic [4:0]                    rf_rs2;
  logic [31:0]                   rf_rs1_data;
  logic [31:0]                   rf_rs2_data;

  logic [4:0]                    wb_rd;
  logic                          wb_regwrite;
  logic [31:0]                   wb_data;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [IDX_W-1:0]              rsp_req;
  logic [TAG_W-1:0]              rsp_tag;
  logic [31:0]                   rsp_rs1_data;
  logic [31:0]                   rsp_rs2_data;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_tag,
    input  rf_rs1_data, rf_rs2_data,
    input  wb_rd, wb_regwrite, wb_data,
    input  rsp_ready,
    output req_ready, rf_rs1, rf_rs2,
    output rsp_valid, rsp_req, rsp_tag, rsp_rs1_data, rsp_rs2_data
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_tag,
    output rf_rs1_data, rf_rs2_data,
    output wb_rd, wb_regwrite, wb_data,
    output rsp_ready,
    input  req_ready, rf_rs1, rf_rs2,
    input  rsp_valid, rsp_req, rsp_tag, rsp_rs1_data, rsp_rs2_data
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the register file's two read ports among NUM_REQ issue-stage
// requesters; registers both operands (x0 forced to zero, commit bypassed) plus the tag.

module regfile_operand_sel (
  input  logic [4:0]  idx,
  input  logic [31:0] rf_data,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] data
);
  // x0 is not stored in the file; the commit landing this edge is not yet visible in it
  always_comb begin
    if (idx == 5'd0)                            data = '0;
    else if (wb_regwrite && (wb_rd == idx))     data = wb_data;
    else                                        data = rf_data;
  end
endmodule

module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
) (
  input logic                   clk,
  input logic                   reset,
  regfile_read_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic              can_grant;
  logic              grant;

  logic [1:0][4:0]   src_idx;
  logic [1:0][31:0]  src_rf;
  logic [1:0][31:0]  src_data;

  logic [IDX_W-1:0]  rsp_req_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [31:0]       rsp_rs1_q;
  logic [31:0]       rsp_rs2_q;

  // Gated by reset so nothing is handed out while the block is held in reset
  assign can_grant = reset & ((state == EMPTY) | bus.rsp_ready);

  always_comb begin
    win   = '0;
    grant = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
      if (can_grant && !grant && bus.req_valid[cand]) begin
        win   = cand;
        grant = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant) bus.req_ready[win] = 1'b1;
  end

  assign bus.rf_rs1 = grant ? bus.req_rs1[win] : 5'd0;
  assign bus.rf_rs2 = grant ? bus.req_rs2[win] : 5'd0;

  assign src_idx[0] = bus.rf_rs1;
  assign src_idx[1] = bus.rf_rs2;
  assign src_rf[0]  = bus.rf_rs1_data;
  assign src_rf[1]  = bus.rf_rs2_data;

  for (genvar l = 0; l < 2; l++) begin : g_opnd
    regfile_operand_sel u_sel (
      .idx         (src_idx[l]),
      .rf_data     (src_rf[l]),
      .wb_regwrite (bus.wb_regwrite),
      .wb_rd       (bus.wb_rd),
      .wb_data     (bus.wb_data),
      .data        (src_data[l])
    );
  end

  // Payload only moves on a grant, so a held response never picks up later bypasses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      rr_ptr    <= '0;
      rsp_req_q <= '0;
      rsp_tag_q <= '0;
      rsp_rs1_q <= '0;
      rsp_rs2_q <= '0;
    end else begin
      if (grant) begin
        state     <= FULL;
        rsp_req_q <= win;
        rsp_tag_q <= bus.req_tag[win];
        rsp_rs1_q <= src_data[0];
        rsp_rs2_q <= src_data[1];
        rr_ptr    <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end else if (state == FULL && bus.rsp_ready) begin
        state     <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid    = (state == FULL);
  assign bus.rsp_req      = rsp_req_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.rsp_rs1_data = rsp_rs1_q;
  assign bus.rsp_rs2_data = rsp_rs2_q;

  a_grant_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(bus.req_ready));
  a_grant_needs_valid : assert property (@(posedge clk) disable iff (!reset)
    (bus.req_ready & ~bus.req_valid) == '0);
  a_hold_stable : assert property (@(posedge clk) disable iff (!reset)
    (state == FULL && !bus.rsp_ready) |=>
      (state == FULL) && $stable(rsp_req_q) && $stable(rsp_tag_q) &&
      $stable(rsp_rs1_q) && $stable(rsp_rs2_q));
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: vector table, directed corner
// sequences and a long random run against a response scoreboard.
module tb_regfile_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 4;
  localparam int IDX_W   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] regs [32];
  always_comb begin
    bus.rf_rs1_data = regs[bus.rf_rs1];
    bus.rf_rs2_data = regs[bus.rf_rs2];
  end

  typedef struct {
    logic [IDX_W-1:0] req;
    logic [TAG_W-1:0] tag;
    logic [31:0]      d1;
    logic [31:0]      d2;
  } rsp_t;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic               rdy;
    logic [NUM_REQ-1:0] exp_ready;
  } vec_t;

  rsp_t q[$];
  int   m_ptr;
  int   wait_cnt [NUM_REQ];
  int   max_wait;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.wb_regwrite && bus.wb_rd == idx) return bus.wb_data;
    return regs[idx];
  endfunction

  task automatic model_clear();
    q.delete();
    m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
  endtask

  // One clock: predict grant, check comb outputs and held response, update scoreboard.
  task automatic cycle();
    int   w, best, d;
    bit   g;
    rsp_t e;
    logic [NUM_REQ-1:0] exp_rdy;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wd;
    #1;
    best = NUM_REQ;
    w    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i]) begin
        d = (i - m_ptr + NUM_REQ) % NUM_REQ;
        if (d < best) begin best = d; w = i; end
      end
    end
    g = (best < NUM_REQ) && (q.size() == 0 || bus.rsp_ready);
    exp_rdy = '0;
    if (g) exp_rdy[w] = 1'b1;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("rf_rs1", bus.rf_rs1, g ? bus.req_rs1[w] : 5'd0);
    chk("rf_rs2", bus.rf_rs2, g ? bus.req_rs2[w] : 5'd0);
    chk("rsp_valid", bus.rsp_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rsp_req", bus.rsp_req, q[0].req);
      chk("rsp_tag", bus.rsp_tag, q[0].tag);
      chk("rsp_rs1_data", bus.rsp_rs1_data, q[0].d1);
      chk("rsp_rs2_data", bus.rsp_rs2_data, q[0].d2);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!bus.req_valid[i] || (g && w == i)) wait_cnt[i] = 0;
      else if (g) begin
        wait_cnt[i]++;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    if (q.size() != 0 && bus.rsp_ready) void'(q.pop_front());
    if (g) begin
      e.req = IDX_W'(w);
      e.tag = bus.req_tag[w];
      e.d1  = opnd(bus.req_rs1[w]);
      e.d2  = opnd(bus.req_rs2[w]);
      q.push_back(e);
      m_ptr = (w + 1) % NUM_REQ;
    end
    wwe = bus.wb_regwrite;
    wrd = bus.wb_rd;
    wd  = bus.wb_data;
    @(posedge clk);
    #1;
    if (wwe && wrd != 5'd0) regs[wrd] = wd;
  endtask

  task automatic idle_inputs();
    bus.req_valid   = '0;
    bus.wb_regwrite = 1'b0;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_rs1[i] = 5'(i + 1);
      bus.req_rs2[i] = 5'(i + 9);
      bus.req_tag[i] = TAG_W'(i + 4);
    end
  endtask

  vec_t        tbl [12];
  logic [31:0] held1;
  logic [31:0] held2;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    regs[0] = 32'hBAD0_BAD0;
    max_wait = 0;
    model_clear();

    tbl[0]  = '{4'hF, 1'b1, 4'b0001};
    tbl[1]  = '{4'hF, 1'b1, 4'b0010};
    tbl[2]  = '{4'hF, 1'b1, 4'b0100};
    tbl[3]  = '{4'hF, 1'b1, 4'b1000};
    tbl[4]  = '{4'hF, 1'b1, 4'b0001};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010};
    tbl[6]  = '{4'hF, 1'b1, 4'b0100};
    tbl[7]  = '{4'hF, 1'b1, 4'b1000};
    tbl[8]  = '{4'hF, 1'b0, 4'b0000};
    tbl[9]  = '{4'hA, 1'b1, 4'b0010};
    tbl[10] = '{4'hA, 1'b1, 4'b1000};
    tbl[11] = '{4'h0, 1'b1, 4'b0000};

    // reset: no grant while low, response cleared
    reset = 1'b0;
    idle_inputs();
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_grant", bus.req_ready, 4'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_req", bus.rsp_req, 2'd0);
    chk("rst_rsp_tag", bus.rsp_tag, 4'h0);
    chk("rst_rsp_rs1", bus.rsp_rs1_data, 32'd0);
    chk("rst_rsp_rs2", bus.rsp_rs2_data, 32'd0);
    reset = 1'b1;

    // get FULL with ptr moved, then async reset mid-cycle
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    cycle();
    cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rsp_valid", bus.rsp_valid, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // vector table: round robin from req 0, backpressure, sparse valids
    for (int i = 0; i < 12; i++) begin
      bus.req_valid = tbl[i].valid;
      bus.rsp_ready = tbl[i].rdy;
      for (int r = 0; r < NUM_REQ; r++) bus.req_tag[r] = TAG_W'(r + i);
      #1;
      chk("tbl_req_ready", bus.req_ready, tbl[i].exp_ready);
      cycle();
    end

    // commit bypass on rs1, x0 on rs2
    idle_inputs();
    regs[5]          = 32'h5555_5555;
    bus.req_valid    = 4'b0100;
    bus.req_rs1[2]   = 5'd5;
    bus.req_rs2[2]   = 5'd0;
    bus.wb_regwrite  = 1'b1;
    bus.wb_rd        = 5'd5;
    bus.wb_data      = 32'hDEAD_BEEF;
    bus.rsp_ready    = 1'b1;
    cycle();
    idle_inputs();
    #1;
    chk("bypass_rs1", bus.rsp_rs1_data, 32'hDEAD_BEEF);
    chk("x0_rs2", bus.rsp_rs2_data, 32'd0);
    chk("bypass_req", bus.rsp_req, 2'd2);
    cycle();

    // backpressure: fill, then hold 3 cycles with req 1 waiting and a bypass aimed at it
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    cycle();
    #1;
    held1 = bus.rsp_rs1_data;
    held2 = bus.rsp_rs2_data;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid   = 4'b0010;
      bus.wb_regwrite = 1'b1;
      bus.wb_rd       = bus.req_rs1[0];
      bus.wb_data     = 32'hC0DE_0000 + 32'(c);
      #1;
      chk("bp_no_grant", bus.req_ready, 4'h0);
      chk("bp_hold_rs1", bus.rsp_rs1_data, held1);
      chk("bp_hold_rs2", bus.rsp_rs2_data, held2);
      cycle();
    end
    bus.wb_regwrite = 1'b0;
    bus.rsp_ready   = 1'b1;
    #1;
    chk("bp_release_grant", bus.req_ready, 4'b0010);
    cycle();
    bus.req_valid = '0;
    cycle();

    // lone req 3, then ptr wraps to 0
    regs[7]        = 32'h0000_1234;
    bus.req_valid  = 4'b1000;
    bus.req_tag[3] = 4'hA;
    bus.req_rs1[3] = 5'd7;
    bus.req_rs2[3] = 5'd3;
    cycle();
    bus.req_valid = 4'hF;
    #1;
    chk("lone3_req", bus.rsp_req, 2'd3);
    chk("lone3_tag", bus.rsp_tag, 4'hA);
    chk("lone3_rs1", bus.rsp_rs1_data, 32'h0000_1234);
    chk("wrap_grant_req0", bus.req_ready, 4'b0001);
    cycle();
    bus.req_valid = '0;
    cycle();

    // random traffic against the scoreboard
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.req_valid = NUM_REQ'($urandom);
      bus.rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_rs1[i] = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom);
        bus.req_rs2[i] = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom);
        bus.req_tag[i] = TAG_W'($urandom);
      end
      bus.wb_regwrite = 1'($urandom_range(1));
      bus.wb_rd       = ($urandom_range(1) == 0) ? bus.req_rs1[$urandom_range(NUM_REQ - 1)]
                                                 : 5'($urandom);
      bus.wb_data     = $urandom;
      cycle();
    end
    idle_inputs();
    bus.rsp_ready = 1'b1;
    cycle();
    cycle();
    chk("max_wait_bound", max_wait < NUM_REQ, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
